// File: rtl/count_seq_ctrl_pkg.sv
// Shared types and constants for the count sequence controller.
// Holds the state encoding, datapath widths and the single-advance helper.
package count_seq_ctrl_pkg;

   localparam int unsigned CNT_W       = 3;
   localparam int unsigned OUT_W       = 4;
   localparam int unsigned PRESC_W_DEF = 8;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'b00,
      ST_RUN   = 2'b01,
      ST_PAUSE = 2'b10,
      ST_STEP  = 2'b11
   } state_e;

   typedef struct packed {
      logic [CNT_W-1:0] count;
      logic             tc;
   } adv_t;

   // One advance of the counter; lim is inclusive and wrapping raises tc.
   function automatic adv_t advance(input logic [CNT_W-1:0] cnt,
                                    input logic [CNT_W-1:0] lim,
                                    input logic             up);
      adv_t r;
      r.count = cnt;
      r.tc    = 1'b0;
      if (up) begin
         if (cnt == lim) begin
            r.count = '0;
            r.tc    = 1'b1;
         end else begin
            r.count = cnt + CNT_W'(1);
         end
      end else begin
         if (cnt == '0) begin
            r.count = lim;
            r.tc    = 1'b1;
         end else begin
            r.count = cnt - CNT_W'(1);
         end
      end
      return r;
   endfunction

endpackage

// File: rtl/count_seq_ctrl_if.sv
// Command/status bundle between the run-control source and the counter.
// The master issues commands and configuration; the slave returns count status.
interface count_seq_ctrl_if #(
   parameter int unsigned PRESC_W = 8
);
   import count_seq_ctrl_pkg::*;

   logic               start;
   logic               stop;
   logic               step;
   logic               dir_up;
   logic [CNT_W-1:0]   limit;
   logic [PRESC_W-1:0] presc_div;
   logic [OUT_W-1:0]   count;
   logic               tc;
   logic               busy;
   logic [1:0]         state;

   modport master (
      output start, stop, step, dir_up, limit, presc_div,
      input  count, tc, busy, state
   );

   modport slave (
      input  start, stop, step, dir_up, limit, presc_div,
      output count, tc, busy, state
   );

endinterface

// File: rtl/count_seq_ctrl_prescaler.sv
// Advance-rate prescaler: ticks once every div+1 enabled cycles.
// A shrinking div is caught by the >= compare so the counter never overshoots.
module count_seq_ctrl_prescaler #(
   parameter int unsigned W = 8
) (
   input  logic         clk,
   input  logic         re,
   input  logic         en,
   input  logic         clr,
   input  logic [W-1:0] div,
   output logic         tick_c
);

   logic [W-1:0] cnt_q;
   logic [W-1:0] cnt_d;

   assign tick_c = en && (cnt_q >= div);

   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = '0;
      end else if (en) begin
         cnt_d = tick_c ? '0 : cnt_q + W'(1);
      end
   end

   always_ff @(posedge clk or posedge re) begin
      if (re) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/count_seq_ctrl.sv
// Run controller for the 0..7 counter: start/pause/stop/single-step, direction,
// programmable terminal value and prescaled advance rate.
module count_seq_ctrl
   import count_seq_ctrl_pkg::*;
#(
   parameter int unsigned PRESC_W = PRESC_W_DEF
) (
   input  logic                   clk,
   input  logic                   re,
   count_seq_ctrl_if.slave        bus
);

   state_e           state_q, state_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic [CNT_W-1:0] lim_q, lim_d;
   logic             tc_q, tc_d;
   logic             busy_q, busy_d;
   logic             presc_en;
   logic             presc_clr;
   logic             tick_c;
   adv_t             adv;

   // A stop in RUN freezes the prescaler so PAUSE resumes mid-period.
   assign presc_en  = (state_q == ST_RUN) && !bus.stop;
   assign presc_clr = (state_q == ST_IDLE) && !bus.stop && bus.start;

   count_seq_ctrl_prescaler #(
      .W (PRESC_W)
   ) u_presc (
      .clk    (clk),
      .re     (re),
      .en     (presc_en),
      .clr    (presc_clr),
      .div    (bus.presc_div),
      .tick_c (tick_c)
   );

   always_ff @(posedge clk or posedge re) begin
      if (re) begin
         state_q <= ST_IDLE;
         count_q <= '0;
         lim_q   <= CNT_W'(7);
         tc_q    <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
         lim_q   <= lim_d;
         tc_q    <= tc_d;
         busy_q  <= busy_d;
      end
   end

   // Command priority is stop > start > step.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (!bus.stop) begin
               if (bus.start)     state_d = ST_RUN;
               else if (bus.step) state_d = ST_STEP;
            end
         end
         ST_RUN: begin
            if (bus.stop) state_d = ST_PAUSE;
         end
         ST_PAUSE: begin
            if (bus.stop)       state_d = ST_IDLE;
            else if (bus.start) state_d = ST_RUN;
            else if (bus.step)  state_d = ST_STEP;
         end
         default: state_d = ST_PAUSE;
      endcase
   end

   always_comb begin
      count_d = count_q;
      lim_d   = lim_q;
      tc_d    = 1'b0;
      busy_d  = (state_d == ST_RUN);
      adv     = advance(count_q, lim_q, bus.dir_up);
      case (state_q)
         ST_IDLE: begin
            if (!bus.stop && (bus.start || bus.step)) begin
               lim_d   = bus.limit;
               count_d = (bus.start && !bus.dir_up) ? bus.limit : '0;
            end
         end
         ST_RUN: begin
            if (tick_c) begin
               count_d = adv.count;
               tc_d    = adv.tc;
            end
         end
         ST_PAUSE: begin
            if (bus.stop) count_d = '0;
         end
         default: begin
            count_d = adv.count;
            tc_d    = adv.tc;
         end
      endcase
   end

   assign bus.count = {1'b0, count_q};
   assign bus.tc    = tc_q;
   assign bus.busy  = busy_q;
   assign bus.state = 2'(state_q);

endmodule

// File: tb/tb_count_seq_ctrl.sv
// Scoreboard bench for count_seq_ctrl: directed scenarios then random commands,
// each cycle's expected outputs queued from an arithmetic reference model.
module tb_count_seq_ctrl;
   import count_seq_ctrl_pkg::*;

   localparam int unsigned PW = 8;

   logic clk = 1'b0;
   logic re  = 1'b1;

   count_seq_ctrl_if #(.PRESC_W(PW)) bus ();

   count_seq_ctrl #(.PRESC_W(PW)) dut (
      .clk (clk),
      .re  (re),
      .bus (bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      int state;
      int count;
      int tc;
      int busy;
   } exp_t;

   exp_t q[$];
   int   checks   = 0;
   int   failures = 0;

   // Reference model: mode 0 idle, 1 run, 2 pause, 3 step.
   int m_mode, m_cnt, m_lim, m_pc;

   int cur_lim = 7;
   int cur_div = 0;
   bit cur_up  = 1'b1;

   function automatic void check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
      end
   endfunction

   function automatic void model_reset();
      m_mode = 0;
      m_cnt  = 0;
      m_lim  = 7;
      m_pc   = 0;
   endfunction

   task automatic cycle(input bit st, input bit sp, input bit sk, input bit up,
                        input int lim, input int div, input bit rst);
      exp_t e;
      bit   adv;
      bit   wrap;
      @(negedge clk);
      #1;
      re            = rst;
      bus.start     = st;
      bus.stop      = sp;
      bus.step      = sk;
      bus.dir_up    = up;
      bus.limit     = 3'(lim);
      bus.presc_div = 8'(div);
      adv  = 1'b0;
      wrap = 1'b0;
      if (rst) begin
         model_reset();
      end else begin
         case (m_mode)
            0: begin
               if (!sp && st) begin
                  m_mode = 1; m_lim = lim; m_cnt = up ? 0 : lim; m_pc = 0;
               end else if (!sp && sk) begin
                  m_mode = 3; m_lim = lim; m_cnt = 0;
               end
            end
            1: begin
               if (sp) m_mode = 2;
               else if (m_pc >= div) begin adv = 1'b1; m_pc = 0; end
               else m_pc++;
            end
            2: begin
               if (sp) begin m_mode = 0; m_cnt = 0; end
               else if (st) m_mode = 1;
               else if (sk) m_mode = 3;
            end
            default: begin adv = 1'b1; m_mode = 2; end
         endcase
         if (adv) begin
            if (up) begin
               wrap  = (m_cnt == m_lim);
               m_cnt = (m_cnt + 1) % (m_lim + 1);
            end else begin
               wrap  = (m_cnt == 0);
               m_cnt = (m_cnt + m_lim) % (m_lim + 1);
            end
         end
      end
      e = '{m_mode, m_cnt, int'(wrap), int'(m_mode == 1)};
      q.push_back(e);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b0, cur_up, cur_lim, cur_div, 1'b0);
   endtask

   task automatic cmd(input bit st, input bit sp, input bit sk);
      cycle(st, sp, sk, cur_up, cur_lim, cur_div, 1'b0);
   endtask

   // Asynchronous reset between edges; outputs must clear without waiting for a clock.
   task automatic async_reset();
      exp_t e;
      #2;
      re = 1'b1;
      #1;
      check("rst_count", int'(bus.count), 0);
      check("rst_state", int'(bus.state), 0);
      check("rst_tc",    int'(bus.tc),    0);
      check("rst_busy",  int'(bus.busy),  0);
      model_reset();
      q.delete();
      e = '{0, 0, 0, 0};
      q.push_back(e);
      cycle(1'b0, 1'b0, 1'b0, cur_up, cur_lim, cur_div, 1'b1);
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge clk);
         if (q.size() > 0) begin
            e = q.pop_front();
            check("state", int'(bus.state), e.state);
            check("count", int'(bus.count), e.count);
            check("tc",    int'(bus.tc),    e.tc);
            check("busy",  int'(bus.busy),  e.busy);
         end
      end
   end

   initial begin : stim
      int r;
      bus.start = 1'b0; bus.stop = 1'b0; bus.step = 1'b0;
      bus.dir_up = 1'b1; bus.limit = 3'd7; bus.presc_div = 8'd0;
      model_reset();
      cycle(1'b0, 1'b0, 1'b0, 1'b1, 7, 0, 1'b1);
      cycle(1'b0, 1'b0, 1'b0, 1'b1, 7, 0, 1'b1);

      // Full up-count wrap at maximum rate.
      cur_lim = 7; cur_div = 0; cur_up = 1'b1;
      cmd(1'b1, 1'b0, 1'b0);
      idle(10);

      // Reset while running at count 5.
      for (int i = 0; i < 20 && m_cnt != 5; i++) idle(1);
      async_reset();
      idle(2);

      // Down count with prescale of three.
      cur_lim = 4; cur_div = 2; cur_up = 1'b0;
      cmd(1'b1, 1'b0, 1'b0);
      idle(18);
      cmd(1'b0, 1'b1, 1'b0);
      cmd(1'b0, 1'b1, 1'b0);

      // Pause at 3, single step, then stop back to idle.
      cur_lim = 7; cur_div = 0; cur_up = 1'b1;
      cmd(1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 20 && m_cnt != 3; i++) idle(1);
      cmd(1'b0, 1'b1, 1'b0);
      idle(2);
      cmd(1'b0, 1'b0, 1'b1);
      idle(2);
      cmd(1'b0, 1'b1, 1'b0);
      idle(1);

      // Step from idle, then start+stop collisions.
      cmd(1'b0, 1'b0, 1'b1);
      idle(1);
      cmd(1'b0, 1'b1, 1'b0);
      cmd(1'b1, 1'b1, 1'b0);
      cmd(1'b1, 1'b0, 1'b0);
      idle(3);
      cmd(1'b1, 1'b1, 1'b1);
      cmd(1'b1, 1'b0, 1'b0);
      idle(2);
      cmd(1'b0, 1'b1, 1'b0);
      cmd(1'b0, 1'b1, 1'b0);

      // Zero limit: tc every advance.
      cur_lim = 0; cur_div = 0; cur_up = 1'b1;
      cmd(1'b1, 1'b0, 1'b0);
      idle(6);
      cur_up = 1'b0;
      idle(3);
      cmd(1'b0, 1'b1, 1'b0);
      cmd(1'b0, 1'b1, 1'b0);

      // Random commands, live direction/divider changes and occasional resets.
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 3) == 0) cur_up = ~cur_up;
         if ($urandom_range(0, 19) == 0) cur_div = $urandom_range(0, 5);
         cur_lim = $urandom_range(0, 7);
         r = $urandom_range(0, 299);
         if (r == 0) begin
            async_reset();
         end else begin
            cmd($urandom_range(0, 7) == 0, $urandom_range(0, 11) == 0,
                $urandom_range(0, 9) == 0);
         end
      end

      repeat (2) @(negedge clk);
      #2;
      check("queue_drained", q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
